// File: rtl/count_lockstep_checker.sv
// Lockstep checker for a primary/shadow up-counter pair: flags disagreement or illegal
// steps, filters short glitches and latches a sticky fault after consecutive bad samples.
module count_lockstep_checker #(
    parameter int WIDTH          = 8,
    parameter int MISMATCH_LIMIT = 2,
    parameter int FAULT_CNT_W    = 4
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   enable,
    input  logic [WIDTH-1:0]       count_a,
    input  logic [WIDTH-1:0]       count_b,
    input  logic                   clear_fault,
    output logic                   armed,
    output logic                   mismatch,
    output logic                   fault,
    output logic [1:0]             fault_code,
    output logic [FAULT_CNT_W-1:0] fault_count
);

    localparam int CONSEC_W = $clog2(MISMATCH_LIMIT + 1);
    localparam logic [CONSEC_W-1:0] LIMIT = CONSEC_W'(MISMATCH_LIMIT);

    typedef enum logic [1:0] {
        S_IDLE,
        S_ARMED,
        S_SUSPECT,
        S_FAULT
    } state_e;

    state_e                 state_q, state_d;
    logic [WIDTH-1:0]       prev_a_q;
    logic                   prev_en_q;
    logic [CONSEC_W-1:0]    consec_q, consec_d;
    logic [1:0]             kind_q, kind_d;
    logic                   mismatch_q, mismatch_d;
    logic [1:0]             fault_code_q, fault_code_d;
    logic [FAULT_CNT_W-1:0] fault_count_q, fault_count_d;

    logic [WIDTH-1:0] expected_a;
    logic             dis, step, err;
    logic [1:0]       cause;
    logic             enter_fault;

    // Wraps mod 2^WIDTH, so an enabled step from all-ones to zero is legal.
    assign expected_a = prev_a_q + {{(WIDTH-1){1'b0}}, prev_en_q};
    assign dis        = (count_a != count_b);
    assign step       = (count_a != expected_a);
    assign err        = dis | step;
    assign cause      = {step, dis};

    always_comb begin
        // NOTE: every combinational output gets a default first so no path can infer a latch.
        state_d       = state_q;
        consec_d      = consec_q;
        kind_d        = kind_q;
        mismatch_d    = 1'b0;
        fault_code_d  = fault_code_q;
        fault_count_d = fault_count_q;
        enter_fault   = 1'b0;

        unique case (state_q)
            S_IDLE: state_d = S_ARMED;
            S_ARMED: begin
                mismatch_d = err;
                if (err) begin
                    consec_d = CONSEC_W'(1);
                    kind_d   = cause;
                    if (MISMATCH_LIMIT == 1) enter_fault = 1'b1;
                    else                     state_d     = S_SUSPECT;
                end
            end
            S_SUSPECT: begin
                mismatch_d = err;
                if (!err) begin
                    state_d  = S_ARMED;
                    consec_d = '0;
                    kind_d   = '0;
                end else begin
                    consec_d = consec_q + 1'b1;
                    kind_d   = kind_q | cause;
                    if (consec_q + 1'b1 == LIMIT) enter_fault = 1'b1;
                end
            end
            S_FAULT: begin
                // Clear takes priority; inputs are not inspected while faulted.
                if (clear_fault) begin
                    state_d      = S_IDLE;
                    fault_code_d = '0;
                end
            end
            default: state_d = S_IDLE;
        endcase

        if (enter_fault) begin
            state_d      = S_FAULT;
            fault_code_d = kind_d;
            kind_d       = '0;
            consec_d     = '0;
            if (fault_count_q != '1) fault_count_d = fault_count_q + 1'b1;
        end
    end

    // NOTE: sequential state uses non-blocking assignments so all registers update together.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q       <= S_IDLE;
            prev_a_q      <= '0;
            prev_en_q     <= 1'b0;
            consec_q      <= '0;
            kind_q        <= '0;
            mismatch_q    <= 1'b0;
            fault_code_q  <= '0;
            fault_count_q <= '0;
        end else begin
            state_q       <= state_d;
            prev_a_q      <= count_a;
            prev_en_q     <= enable;
            consec_q      <= consec_d;
            kind_q        <= kind_d;
            mismatch_q    <= mismatch_d;
            fault_code_q  <= fault_code_d;
            fault_count_q <= fault_count_d;
        end
    end

    assign armed       = (state_q == S_ARMED) || (state_q == S_SUSPECT);
    assign fault       = (state_q == S_FAULT);
    assign mismatch    = mismatch_q;
    assign fault_code  = fault_code_q;
    assign fault_count = fault_count_q;

endmodule

// File: tb/tb_count_lockstep_checker.sv
// Directed, table-driven bench for count_lockstep_checker (2-bit fault counter to reach saturation).
module tb_count_lockstep_checker;

    localparam int W  = 8;
    localparam int CW = 2;

    logic          clk = 1'b0;
    logic          reset;
    logic          enable;
    logic [W-1:0]  count_a;
    logic [W-1:0]  count_b;
    logic          clear_fault;
    logic          armed;
    logic          mismatch;
    logic          fault;
    logic [1:0]    fault_code;
    logic [CW-1:0] fault_count;

    count_lockstep_checker #(
        .WIDTH         (W),
        .MISMATCH_LIMIT(2),
        .FAULT_CNT_W   (CW)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .enable     (enable),
        .count_a    (count_a),
        .count_b    (count_b),
        .clear_fault(clear_fault),
        .armed      (armed),
        .mismatch   (mismatch),
        .fault      (fault),
        .fault_code (fault_code),
        .fault_count(fault_count)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic          en;
        logic [W-1:0]  a;
        logic [W-1:0]  b;
        logic          clr;
        logic          x_armed;
        logic          x_mm;
        logic          x_fault;
        logic [1:0]    x_code;
        logic [CW-1:0] x_cnt;
    } vec_t;

    vec_t vecs[$];
    int   n_checks = 0;
    int   n_fail   = 0;

    function automatic vec_t mk(input logic en, input logic [W-1:0] a, input logic [W-1:0] b,
                                input logic clr, input logic x_armed, input logic x_mm,
                                input logic x_fault, input logic [1:0] x_code,
                                input logic [CW-1:0] x_cnt);
        vec_t v;
        v.en = en; v.a = a; v.b = b; v.clr = clr;
        v.x_armed = x_armed; v.x_mm = x_mm; v.x_fault = x_fault;
        v.x_code = x_code; v.x_cnt = x_cnt;
        return v;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp_v);
        n_checks++;
        if (act !== exp_v) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp_v, $time);
        end
    endtask

    task automatic check_all(input string tag, input logic x_armed, input logic x_mm,
                             input logic x_fault, input logic [1:0] x_code,
                             input logic [CW-1:0] x_cnt);
        check({tag, ".armed"},       32'(armed),       32'(x_armed));
        check({tag, ".mismatch"},    32'(mismatch),    32'(x_mm));
        check({tag, ".fault"},       32'(fault),       32'(x_fault));
        check({tag, ".fault_code"},  32'(fault_code),  32'(x_code));
        check({tag, ".fault_count"}, 32'(fault_count), 32'(x_cnt));
    endtask

    task automatic apply(input vec_t v, input string tag);
        enable      = v.en;
        count_a     = v.a;
        count_b     = v.b;
        clear_fault = v.clr;
        @(posedge clk);
        #1;
        check_all(tag, v.x_armed, v.x_mm, v.x_fault, v.x_code, v.x_cnt);
    endtask

    initial begin
        logic [W-1:0] x;

        // First edge is IDLE capture; then a clean count through the 0xFF->0x00 wrap.
        for (int i = 0; i < 12; i++) begin
            x = 8'hF8 + W'(i);
            vecs.push_back(mk(1, x, x, 0, 1, 0, 0, 2'b00, 0));
        end
        vecs.push_back(mk(0, 8'h04, 8'h04, 0, 1, 0, 0, 2'b00, 0)); // last enabled step
        vecs.push_back(mk(1, 8'h04, 8'h04, 0, 1, 0, 0, 2'b00, 0)); // legal hold
        // Single-cycle disagreement is filtered.
        vecs.push_back(mk(1, 8'h05, 8'h01, 0, 1, 1, 0, 2'b00, 0));
        vecs.push_back(mk(1, 8'h06, 8'h06, 0, 1, 0, 0, 2'b00, 0));
        // Two disagreements -> fault code 01.
        vecs.push_back(mk(1, 8'h07, 8'h00, 0, 1, 1, 0, 2'b00, 0));
        vecs.push_back(mk(1, 8'h08, 8'h09, 0, 0, 1, 1, 2'b01, 1));
        vecs.push_back(mk(1, 8'h09, 8'h09, 0, 0, 0, 1, 2'b01, 1)); // sticky
        vecs.push_back(mk(1, 8'h0A, 8'h00, 1, 0, 0, 0, 2'b00, 1)); // clear beats error
        vecs.push_back(mk(1, 8'h10, 8'h10, 0, 1, 0, 0, 2'b00, 1)); // IDLE -> ARMED
        // Two illegal steps 0x10->0x12->0x14 -> fault code 10.
        vecs.push_back(mk(1, 8'h12, 8'h12, 0, 1, 1, 0, 2'b00, 1));
        vecs.push_back(mk(1, 8'h14, 8'h14, 0, 0, 1, 1, 2'b10, 2));
        vecs.push_back(mk(0, 8'h14, 8'h14, 1, 0, 0, 0, 2'b00, 2));
        // Disagreement then illegal step -> fault code 11.
        vecs.push_back(mk(1, 8'h20, 8'h20, 0, 1, 0, 0, 2'b00, 2));
        vecs.push_back(mk(1, 8'h21, 8'h22, 0, 1, 1, 0, 2'b00, 2));
        vecs.push_back(mk(1, 8'h30, 8'h30, 0, 0, 1, 1, 2'b11, 3));
        vecs.push_back(mk(0, 8'h00, 8'h00, 0, 0, 0, 1, 2'b11, 3));
        vecs.push_back(mk(0, 8'h00, 8'h00, 1, 0, 0, 0, 2'b00, 3));
        // Fourth fault: counter saturates at 3.
        vecs.push_back(mk(1, 8'h40, 8'h40, 0, 1, 0, 0, 2'b00, 3));
        vecs.push_back(mk(1, 8'h41, 8'h00, 0, 1, 1, 0, 2'b00, 3));
        vecs.push_back(mk(1, 8'h42, 8'h00, 0, 0, 1, 1, 2'b01, 3));
        vecs.push_back(mk(0, 8'h43, 8'h43, 1, 0, 0, 0, 2'b00, 3));
        // clear_fault outside FAULT has no effect.
        vecs.push_back(mk(1, 8'h50, 8'h50, 1, 1, 0, 0, 2'b00, 3));
        vecs.push_back(mk(1, 8'h51, 8'h51, 1, 1, 0, 0, 2'b00, 3));
        // Re-enter FAULT so the reset test starts from non-zero outputs.
        vecs.push_back(mk(1, 8'h52, 8'h00, 0, 1, 1, 0, 2'b00, 3));
        vecs.push_back(mk(1, 8'h53, 8'h00, 0, 0, 1, 1, 2'b01, 3));

        reset       = 1'b1;
        enable      = 1'b0;
        count_a     = '0;
        count_b     = '0;
        clear_fault = 1'b0;
        #12;
        check_all("reset", 0, 0, 0, 2'b00, 0);
        reset = 1'b0;
        #1;
        check_all("post_release", 0, 0, 0, 2'b00, 0);

        foreach (vecs[i]) apply(vecs[i], $sformatf("vec%0d", i));

        // Asynchronous reset between edges clears outputs without a clock.
        #3;
        reset = 1'b1;
        #1;
        check_all("async_reset", 0, 0, 0, 2'b00, 0);
        @(negedge clk);
        reset = 1'b0;
        apply(mk(1, 8'h77, 8'h77, 0, 1, 0, 0, 2'b00, 0), "rearm");
        apply(mk(1, 8'h78, 8'h78, 0, 1, 0, 0, 2'b00, 0), "rearm_count");

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
